// File: rtl/pc_fetch_if.sv
// Fetch-sequencer bus: hazard/branch inputs, imem handshake and PC control outputs.
// master = sequencer side, slave = surrounding pipeline / PC register side.
interface pc_fetch_if #(
    parameter int OFFSET_W = 16,
    parameter int JUMP_W   = 22
);
    logic                stall;
    logic                br_taken;
    logic [OFFSET_W-1:0] br_offset;
    logic                jmp;
    logic [JUMP_W-1:0]   jmp_target;
    logic                imem_ready;
    // act encoding: 0 None, 1 Inc, 2 Offset, 3 Jump
    logic [1:0]          act;
    logic [OFFSET_W-1:0] offset;
    logic [JUMP_W-1:0]   jump;
    logic                imem_req;
    logic                if_valid;
    logic                flush;
    logic                busy;

    modport master (
        input  stall, br_taken, br_offset, jmp, jmp_target, imem_ready,
        output act, offset, jump, imem_req, if_valid, flush, busy
    );

    modport slave (
        output stall, br_taken, br_offset, jmp, jmp_target, imem_ready,
        input  act, offset, jump, imem_req, if_valid, flush, busy
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: picks the PC action each cycle (inc/stall/branch/jump)
// and parks a redirect in DRAIN while an imem fetch is still outstanding.
module pc_fetch_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int OFFSET_W    = 16,
    parameter int JUMP_W      = 22,
    parameter int BOOT_CYCLES = 2
) (
    input logic        clk,
    input logic        rst,
    pc_fetch_if.master bus
);
    localparam logic [1:0] ACT_NONE   = 2'd0;
    localparam logic [1:0] ACT_INC    = 2'd1;
    localparam logic [1:0] ACT_OFFSET = 2'd2;
    localparam logic [1:0] ACT_JUMP   = 2'd3;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // With no boot delay the sequencer comes out of reset directly in RUN.
    localparam logic [1:0] S_RESET = (BOOT_CYCLES == 0) ? S_RUN : S_BOOT;
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);

    if (ADDR_W < JUMP_W) begin : g_bad_cfg
        $error("pc_fetch_sequencer: jump field wider than PC");
    end

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    boot_cnt_q, boot_cnt_d;
    logic                pend_jmp_q, pend_jmp_d;
    logic [OFFSET_W-1:0] pend_off_q, pend_off_d;
    logic [JUMP_W-1:0]   pend_tgt_q, pend_tgt_d;

    logic [1:0]          act_c;
    logic [OFFSET_W-1:0] offset_c;
    logic [JUMP_W-1:0]   jump_c;
    logic                req_c, valid_c, flush_c;

    logic redir, redir_is_jmp;
    logic drn_is_jmp;
    logic [OFFSET_W-1:0] drn_off;

    // Branch is older than the jump in ID, so it wins and the jump is dropped.
    assign redir        = bus.br_taken | bus.jmp;
    assign redir_is_jmp = ~bus.br_taken & bus.jmp;

    // A branch resolving during DRAIN replaces whatever is pending.
    assign drn_is_jmp = bus.br_taken ? 1'b0 : pend_jmp_q;
    assign drn_off    = bus.br_taken ? bus.br_offset : pend_off_q;

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pend_jmp_d = pend_jmp_q;
        pend_off_d = pend_off_q;
        pend_tgt_d = pend_tgt_q;
        act_c      = ACT_NONE;
        offset_c   = '0;
        jump_c     = '0;
        req_c      = 1'b0;
        valid_c    = 1'b0;
        flush_c    = 1'b0;

        case (state_q)
            S_BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = S_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                if (redir) begin
                    flush_c = 1'b1;
                    if (bus.imem_ready || bus.stall) begin
                        req_c = ~bus.stall;
                        if (redir_is_jmp) begin
                            act_c  = ACT_JUMP;
                            jump_c = bus.jmp_target;
                        end else begin
                            act_c    = ACT_OFFSET;
                            offset_c = bus.br_offset;
                        end
                    end else begin
                        // Fetch still outstanding: hold the PC and remember the redirect.
                        req_c      = 1'b1;
                        pend_jmp_d = redir_is_jmp;
                        pend_off_d = bus.br_offset;
                        pend_tgt_d = bus.jmp_target;
                        state_d    = S_DRAIN;
                    end
                end else if (!bus.stall) begin
                    req_c = 1'b1;
                    if (bus.imem_ready) begin
                        act_c   = ACT_INC;
                        valid_c = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                req_c = 1'b1;
                if (bus.br_taken) begin
                    pend_jmp_d = 1'b0;
                    pend_off_d = bus.br_offset;
                end
                if (bus.imem_ready) begin
                    state_d = S_RUN;
                    if (drn_is_jmp) begin
                        act_c  = ACT_JUMP;
                        jump_c = pend_tgt_q;
                    end else begin
                        act_c    = ACT_OFFSET;
                        offset_c = drn_off;
                    end
                end
            end

            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET;
            boot_cnt_q <= '0;
            pend_jmp_q <= 1'b0;
            pend_off_q <= '0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_jmp_q <= pend_jmp_d;
            pend_off_q <= pend_off_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Outputs are forced idle while reset is held, independent of the clock.
    assign bus.act      = rst ? ACT_NONE : act_c;
    assign bus.offset   = rst ? '0 : offset_c;
    assign bus.jump     = rst ? '0 : jump_c;
    assign bus.imem_req = ~rst & req_c;
    assign bus.if_valid = ~rst & valid_c;
    assign bus.flush    = ~rst & flush_c;
    assign bus.busy     = ~rst & (state_q == S_DRAIN);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: linear sequence of steps, each checked
// with an immediate assertion against hand-computed expectations.
module tb_pc_fetch_sequencer;
    localparam int OFFSET_W = 16;
    localparam int JUMP_W   = 22;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] INC  = 2'd1;
    localparam logic [1:0] OFS  = 2'd2;
    localparam logic [1:0] JMP  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pc_fetch_if #(.OFFSET_W(OFFSET_W), .JUMP_W(JUMP_W)) bus ();

    pc_fetch_sequencer #(
        .ADDR_W(32), .OFFSET_W(OFFSET_W), .JUMP_W(JUMP_W), .BOOT_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic set_in(input logic st, input logic bt, input logic [15:0] bo,
                          input logic j, input logic [21:0] jt, input logic rdy);
        bus.stall      = st;
        bus.br_taken   = bt;
        bus.br_offset  = bo;
        bus.jmp        = j;
        bus.jmp_target = jt;
        bus.imem_ready = rdy;
    endtask

    task automatic chk(input string tag, input logic [1:0] ea, input logic [15:0] eo,
                       input logic [21:0] ej, input logic ereq, input logic evld,
                       input logic efl, input logic ebsy);
        logic [43:0] obs, exp;
        obs = {bus.act, bus.offset, bus.jump, bus.imem_req, bus.if_valid, bus.flush, bus.busy};
        exp = {ea, eo, ej, ereq, evld, efl, ebsy};
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got act=%0d off=%h jmp=%h req=%b vld=%b fl=%b busy=%b, want act=%0d off=%h jmp=%h req=%b vld=%b fl=%b busy=%b",
                   tag, bus.act, bus.offset, bus.jump, bus.imem_req, bus.if_valid, bus.flush, bus.busy,
                   ea, eo, ej, ereq, evld, efl, ebsy);
        end
    endtask

    // One clocked step: drive after the falling edge, check before the rising edge.
    task automatic step(input string tag,
                        input logic st, input logic bt, input logic [15:0] bo,
                        input logic j, input logic [21:0] jt, input logic rdy,
                        input logic [1:0] ea, input logic [15:0] eo, input logic [21:0] ej,
                        input logic ereq, input logic evld, input logic efl, input logic ebsy);
        @(negedge clk);
        set_in(st, bt, bo, j, jt, rdy);
        #1;
        chk(tag, ea, eo, ej, ereq, evld, efl, ebsy);
    endtask

    initial begin
        set_in(0, 1, 16'h1111, 1, 22'h1, 1);
        repeat (2) @(negedge clk);
        #1 chk("reset_hold", NONE, 0, 0, 0, 0, 0, 0);

        // Boot: two idle cycles, inputs ignored, then steady increment.
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 1, 16'h2222, 0, 22'h0, 1);
        #1 chk("boot0", NONE, 0, 0, 0, 0, 0, 0);
        step("boot1", 0, 0, 16'h0, 0, 22'h0, 1, NONE, 0, 0, 0, 0, 0, 0);
        step("inc0",  0, 0, 16'h0, 0, 22'h0, 1, INC,  0, 0, 1, 1, 0, 0);
        step("inc1",  0, 0, 16'h0, 0, 22'h0, 1, INC,  0, 0, 1, 1, 0, 0);

        // Branch beats a simultaneous jump, issued immediately.
        step("br_beats_jmp", 0, 1, 16'hFFFC, 1, 22'h3FFFFF, 1, OFS, 16'hFFFC, 0, 1, 0, 1, 0);
        step("run_wait",     0, 0, 16'h0, 0, 22'h0, 0, NONE, 0, 0, 1, 0, 0, 0);

        // Jump while memory busy: capture, drain 2 more cycles, issue on ready.
        step("jmp_cap",  0, 0, 16'h0, 1, 22'h000100, 0, NONE, 0, 0, 1, 0, 1, 0);
        step("drain_w0", 1, 0, 16'h0, 1, 22'h000003, 0, NONE, 0, 0, 1, 0, 0, 1);
        step("drain_w1", 0, 0, 16'h0, 0, 22'h0, 0, NONE, 0, 0, 1, 0, 0, 1);
        step("drain_iss", 0, 0, 16'h0, 0, 22'h0, 1, JMP, 0, 22'h000100, 1, 0, 0, 1);
        step("run_inc_a", 0, 0, 16'h0, 0, 22'h0, 1, INC, 0, 0, 1, 1, 0, 0);

        // Pending jump overwritten by a later branch; jump never issues.
        step("jmp_cap2",  0, 0, 16'h0, 1, 22'h2ABCDE, 0, NONE, 0, 0, 1, 0, 1, 0);
        step("drain_br",  0, 1, 16'h0008, 0, 22'h0, 0, NONE, 0, 0, 1, 0, 0, 1);
        step("drain_iss2", 0, 0, 16'h0, 0, 22'h0, 1, OFS, 16'h0008, 0, 1, 0, 0, 1);
        step("run_inc_b", 0, 0, 16'h0, 0, 22'h0, 1, INC, 0, 0, 1, 1, 0, 0);

        // Stall holds fetch; a redirect under stall issues with no request.
        step("stall0",   1, 0, 16'h0, 0, 22'h0, 1, NONE, 0, 0, 0, 0, 0, 0);
        step("stall1",   1, 0, 16'h0, 0, 22'h0, 1, NONE, 0, 0, 0, 0, 0, 0);
        step("stall_br", 1, 1, 16'h0040, 0, 22'h0, 0, OFS, 16'h0040, 0, 0, 0, 1, 0);
        step("run_inc_c", 0, 0, 16'h0, 0, 22'h0, 1, INC, 0, 0, 1, 1, 0, 0);
        step("jmp_now",  0, 0, 16'h0, 1, 22'h012345, 1, JMP, 0, 22'h012345, 1, 0, 1, 0);

        // Reset in the middle of DRAIN.
        step("br_cap",   0, 1, 16'h1234, 0, 22'h0, 0, NONE, 0, 0, 1, 0, 1, 0);
        step("drain_w2", 0, 0, 16'h0, 0, 22'h0, 0, NONE, 0, 0, 1, 0, 0, 1);
        #1 rst = 1'b1;
        #1 chk("rst_async", NONE, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(0, 0, 16'h0, 0, 22'h0, 1);
        #1 chk("reboot0", NONE, 0, 0, 0, 0, 0, 0);
        step("reboot1",  0, 0, 16'h0, 0, 22'h0, 1, NONE, 0, 0, 0, 0, 0, 0);
        step("no_pend",  0, 0, 16'h0, 0, 22'h0, 1, INC,  0, 0, 1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
